// File: rtl/disp_window_3x3_pkg.sv
// rtl/disp_window_3x3_pkg.sv - shared types and constants for the disparity window generator
package disp_window_3x3_pkg;

  localparam int DISP_WIDTH = 16;

  // Row-major tap order shared with the median stage: 0..2 top, 3..5 centre, 6..8 bottom
  localparam int WIN_TAPS   = 9;
  localparam int WIN_CENTRE = 4;

  typedef enum logic [1:0] {
    RUN,
    EOL,
    FLUSH,
    EOLF
  } win_state_e;

endpackage

// File: rtl/disp_line_buffer.sv
// rtl/disp_line_buffer.sv - one image row of disparities, synchronous write, combinational read
module disp_line_buffer
  import disp_window_3x3_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int WIDTH = DISP_WIDTH,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read-before-write: the old word is returned in the cycle it is overwritten
  assign rdata = mem[addr];

endmodule

// File: rtl/disp_window_3x3.sv
// rtl/disp_window_3x3.sv - raster-order 3x3 window generator with edge replication
module disp_window_3x3
  import disp_window_3x3_pkg::*;
#(
  parameter int WIDTH = DISP_WIDTH,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_last,
  output logic [WIDTH-1:0] win_1,
  output logic [WIDTH-1:0] win_2,
  output logic [WIDTH-1:0] win_3,
  output logic [WIDTH-1:0] win_4,
  output logic [WIDTH-1:0] win_5,
  output logic [WIDTH-1:0] win_6,
  output logic [WIDTH-1:0] win_7,
  output logic [WIDTH-1:0] win_8,
  output logic [WIDTH-1:0] win_9
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  // Column of three vertical taps: [0] top, [1] mid, [2] bottom
  typedef logic [2:0][WIDTH-1:0] column_t;

  win_state_e state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  column_t p1, p2, nc, wl, wc, wr;
  logic [WIDTH-1:0] lb0_rd, lb1_rd;
  logic accept, step, emit, last, edge_r;
  logic [WIN_TAPS-1:0][WIDTH-1:0] win_q;

  assign in_ready = (state == RUN);
  assign accept   = in_valid && in_ready;

  disp_line_buffer #(.IMG_W(IMG_W), .WIDTH(WIDTH), .AW(CW)) u_lb0 (
    .clk(clk), .we(accept), .addr(col), .wdata(in_data), .rdata(lb0_rd)
  );

  disp_line_buffer #(.IMG_W(IMG_W), .WIDTH(WIDTH), .AW(CW)) u_lb1 (
    .clk(clk), .we(accept), .addr(col), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    step    = 1'b0;
    emit    = 1'b0;
    last    = 1'b0;
    edge_r  = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          step = 1'b1;
          emit = (row != '0) && (col != '0);
          if (col == COL_MAX) state_n = EOL;
        end
      end
      EOL: begin
        emit    = (row != '0);
        edge_r  = 1'b1;
        state_n = (row == ROW_MAX) ? FLUSH : RUN;
      end
      FLUSH: begin
        step = 1'b1;
        emit = (col != '0);
        if (col == COL_MAX) state_n = EOLF;
      end
      EOLF: begin
        emit    = 1'b1;
        last    = 1'b1;
        edge_r  = 1'b1;
        state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // Incoming column plus the top/bottom and left/right replication at the borders
  always_comb begin
    nc[0] = lb1_rd;
    nc[1] = lb0_rd;
    nc[2] = in_data;
    if (state == RUN && row == RW'(1)) nc[0] = lb0_rd;
    if (state == FLUSH)                nc[2] = lb0_rd;
    wl = (step && col == CW'(1)) ? p1 : p2;
    wc = p1;
    wr = edge_r ? p1 : nc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      p1        <= '0;
      p2        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      win_q     <= '0;
    end else begin
      out_valid <= emit;
      out_last  <= last;
      if (emit) begin
        win_q <= {wr[2], wc[2], wl[2], wr[1], wc[1], wl[1], wr[0], wc[0], wl[0]};
      end
      if (step) begin
        p2  <= p1;
        p1  <= nc;
        col <= (col == COL_MAX) ? '0 : col + 1'b1;
      end
      if (state == EOL && row != ROW_MAX) row <= row + 1'b1;
      if (state == EOLF) begin
        row <= '0;
        col <= '0;
      end
    end
  end

  assign win_1 = win_q[0];
  assign win_2 = win_q[1];
  assign win_3 = win_q[2];
  assign win_4 = win_q[3];
  assign win_5 = win_q[4];
  assign win_6 = win_q[5];
  assign win_7 = win_q[6];
  assign win_8 = win_q[7];
  assign win_9 = win_q[8];

endmodule

// File: tb/tb_disp_window_3x3.sv
// tb/tb_disp_window_3x3.sv - self-checking bench for disp_window_3x3 against a clamped-neighbourhood model
module tb_disp_window_3x3;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int DW = 16;

  typedef logic [9*DW-1:0] wvec_t;
  typedef struct packed {
    wvec_t w;
    logic  last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_last;
  logic [DW-1:0] win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9;
  wvec_t         obs_w;

  int checks = 0;
  int failures = 0;
  int vcount = 0;
  int last_cnt = 0;
  int busy_cnt = 0;
  bit prev_act = 1'b0;

  logic [DW-1:0] frame_pix [N];
  exp_t  exp_q [$];
  wvec_t got [$];

  always #5 clk = ~clk;

  disp_window_3x3 #(.WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_last(out_last),
    .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4), .win_5(win_5),
    .win_6(win_6), .win_7(win_7), .win_8(win_8), .win_9(win_9)
  );

  assign obs_w = {win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9};

  task automatic chk(input string tag, input wvec_t obs, input wvec_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: every pixel's 3x3 neighbourhood with coordinates clamped into the image
  task automatic push_model();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        wvec_t w = '0;
        exp_t  e;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int yy = (y + dy < 0) ? 0 : ((y + dy > H - 1) ? H - 1 : y + dy);
            int xx = (x + dx < 0) ? 0 : ((x + dx > W - 1) ? W - 1 : x + dx);
            w = {w[8*DW-1:0], frame_pix[yy*W + xx]};
          end
        end
        e.w    = w;
        e.last = (x == W - 1) && (y == H - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_ready) busy_cnt++;
      if (out_valid) begin
        exp_t e;
        vcount++;
        got.push_back(obs_w);
        if (out_last) last_cnt++;
        chk_int("emit_follows_activity", int'(prev_act), 1);
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_window observed=%0h expected=none", obs_w);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("window", obs_w, e.w);
          chk_int("out_last", int'(out_last), int'(e.last));
        end
      end
      prev_act = (in_valid && in_ready) || !in_ready;
    end else begin
      prev_act = 1'b0;
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit gaps);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc && guard < 50) begin
      in_data  = d;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic send_frame(input bit gaps);
    push_model();
    for (int i = 0; i < N; i++) send(frame_pix[i], gaps);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      step_clk();
      g++;
    end
    repeat (3) step_clk();
    chk_int("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < N; i++) frame_pix[i] = DW'(base + 10 * (i / W) + (i % W));
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) frame_pix[i] = DW'($urandom);
  endtask

  task automatic clear_stats();
    vcount   = 0;
    last_cnt = 0;
    busy_cnt = 0;
    got.delete();
  endtask

  initial begin
    wvec_t tl_w, re_w, fin_w;
    tl_w  = {16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd10, 16'd10, 16'd11};
    re_w  = {16'd2, 16'd3, 16'd3, 16'd12, 16'd13, 16'd13, 16'd22, 16'd23, 16'd23};
    fin_w = {16'd12, 16'd13, 16'd13, 16'd22, 16'd23, 16'd23, 16'd22, 16'd23, 16'd23};

    rst_n = 1'b0;
    repeat (3) step_clk();
    chk_int("reset_out_valid", int'(out_valid), 0);
    chk_int("reset_out_last", int'(out_last), 0);
    chk("reset_window", obs_w, '0);
    rst_n = 1'b1;
    step_clk();
    chk_int("reset_in_ready", int'(in_ready), 1);

    // Full-rate ramp frame with directed corner windows
    fill_ramp(0);
    clear_stats();
    send_frame(1'b0);
    drain();
    chk_int("full_valid_count", vcount, N);
    chk_int("full_last_count", last_cnt, 1);
    chk_int("full_busy_cycles", busy_cnt, H + W + 1);
    chk("top_left_window", got[0], tl_w);
    chk("right_edge_window", got[7], re_w);
    chk("final_window", got[11], fin_w);

    // Gapped input, ramp then random data
    clear_stats();
    send_frame(1'b1);
    drain();
    chk_int("gapped_valid_count", vcount, N);
    fill_rand();
    clear_stats();
    send_frame(1'b1);
    drain();
    chk_int("rand_valid_count", vcount, N);
    chk_int("rand_last_count", last_cnt, 1);

    // Reset mid-frame
    fill_ramp(0);
    push_model();
    for (int i = 0; i < 5; i++) send(frame_pix[i], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_window", obs_w, '0);
    chk_int("async_reset_out_valid", int'(out_valid), 0);
    chk_int("async_reset_out_last", int'(out_last), 0);
    exp_q.delete();
    repeat (2) step_clk();
    @(negedge clk);
    rst_n = 1'b1;
    step_clk();
    clear_stats();
    send_frame(1'b0);
    drain();
    chk_int("post_reset_valid_count", vcount, N);

    // Back-to-back frames, second offset by 100
    clear_stats();
    fill_ramp(0);
    send_frame(1'b0);
    fill_ramp(100);
    send_frame(1'b0);
    drain();
    chk_int("b2b_valid_count", vcount, 2 * N);
    chk_int("b2b_last_count", last_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
